// File: rtl/core_pkg.sv
// Shared opcode, ALU-command and branch-type encodings for the 5-stage core,
// plus the opcode decode table used by the ID stage.
package core_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b101001;
    localparam logic [5:0] OP_BNE  = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    localparam logic [3:0] EXE_NOP = 4'd0;
    localparam logic [3:0] EXE_ADD = 4'd1;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BNE  = 2'd1;
    localparam logic [1:0] BR_BEZ  = 2'd2;
    localparam logic [1:0] BR_JMP  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [3:0] exe_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic [1:0] br_type;
    } idex_ctrl_t;

    typedef struct packed {
        idex_ctrl_t ctrl;
        logic       is_imm;
        logic       dest_is_rt;
    } decode_t;

    // Unknown opcodes fall through to an all-zero (NOP) control word.
    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_ADD:  begin d.ctrl.exe_cmd = EXE_ADD; d.ctrl.wb_en = 1'b1; end
            OP_ADDI: begin d.ctrl.exe_cmd = EXE_ADD; d.ctrl.wb_en = 1'b1;
                           d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            OP_LD:   begin d.ctrl.exe_cmd = EXE_ADD; d.ctrl.wb_en = 1'b1; d.ctrl.mem_read = 1'b1;
                           d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            OP_ST:   begin d.ctrl.exe_cmd = EXE_ADD; d.ctrl.mem_write = 1'b1;
                           d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            OP_BNE:  begin d.ctrl.br_type = BR_BNE; d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            OP_BEZ:  begin d.ctrl.br_type = BR_BEZ; d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            OP_JMP:  begin d.ctrl.br_type = BR_JMP; d.is_imm = 1'b1; d.dest_is_rt = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// IF/WB/EXE/MEM-side inputs and ID/EX outputs of the decode stage.
interface id_stage_pipelined_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            instr_valid;
    logic            flush;
    logic            wb_en;
    logic [RA_W-1:0] wb_dest;
    logic [XLEN-1:0] wb_value;
    logic [RA_W-1:0] exe_dest;
    logic            exe_wb_en;
    logic            exe_mem_read;
    logic [RA_W-1:0] mem_dest;
    logic            mem_wb_en;

    logic            stall;
    logic            idex_valid;
    logic [XLEN-1:0] idex_pc;
    logic [3:0]      idex_exe_cmd;
    logic            idex_mem_read;
    logic            idex_mem_write;
    logic            idex_wb_en;
    logic [1:0]      idex_br_type;
    logic [XLEN-1:0] idex_val1;
    logic [XLEN-1:0] idex_val2;
    logic [XLEN-1:0] idex_st_val;
    logic [RA_W-1:0] idex_dest;
    logic [RA_W-1:0] idex_src1;
    logic [RA_W-1:0] idex_src2;

    modport master (
        output instr_in, pc_in, instr_valid, flush, wb_en, wb_dest, wb_value,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        input  stall, idex_valid, idex_pc, idex_exe_cmd, idex_mem_read, idex_mem_write,
               idex_wb_en, idex_br_type, idex_val1, idex_val2, idex_st_val,
               idex_dest, idex_src1, idex_src2
    );

    modport slave (
        input  instr_in, pc_in, instr_valid, flush, wb_en, wb_dest, wb_value,
               exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
        output stall, idex_valid, idex_pc, idex_exe_cmd, idex_mem_read, idex_mem_write,
               idex_wb_en, idex_br_type, idex_val1, idex_val2, idex_st_val,
               idex_dest, idex_src1, idex_src2
    );
endinterface

// File: rtl/id_stage_pipelined_hazard.sv
// Combinational load-use / RAW hazard detector; a flush in EXE suppresses the stall
// because the instruction in ID is being squashed anyway.
module id_hazard_unit #(
    parameter int RA_W       = 5,
    parameter int FORWARD_EN = 1
) (
    input  logic            instr_valid_i,
    input  logic            flush_i,
    input  logic            two_regs_i,
    input  logic [RA_W-1:0] src1_i,
    input  logic [RA_W-1:0] src2_i,
    input  logic [RA_W-1:0] exe_dest_i,
    input  logic            exe_wb_en_i,
    input  logic            exe_mem_read_i,
    input  logic [RA_W-1:0] mem_dest_i,
    input  logic            mem_wb_en_i,
    output logic            stall_o
);
    localparam logic RAW_ALL = (FORWARD_EN == 0) ? 1'b1 : 1'b0;

    logic hz1_s;
    logic hz2_s;

    // Without forwarding any pending write to a source blocks issue, not only loads.
    always_comb begin
        hz1_s = (src1_i != {RA_W{1'b0}}) &&
                ((exe_wb_en_i && exe_mem_read_i && (src1_i == exe_dest_i)) ||
                 (RAW_ALL && ((exe_wb_en_i && (src1_i == exe_dest_i)) ||
                              (mem_wb_en_i && (src1_i == mem_dest_i)))));
        hz2_s = two_regs_i && (src2_i != {RA_W{1'b0}}) &&
                ((exe_wb_en_i && exe_mem_read_i && (src2_i == exe_dest_i)) ||
                 (RAW_ALL && ((exe_wb_en_i && (src2_i == exe_dest_i)) ||
                              (mem_wb_en_i && (src2_i == mem_dest_i)))));
        stall_o = instr_valid_i && (hz1_s || hz2_s) && !flush_i;
    end
endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS-style decode stage: decode, bypassed register-file read, immediate extension,
// hazard stall and the ID/EX pipeline register.
module id_stage_pipelined
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int FORWARD_EN = 1
) (
    input  logic clock,
    input  logic reset,
    id_stage_pipelined_if.slave bus
);
    localparam int RA_W = $clog2(REG_COUNT);

    logic [XLEN-1:0] rf_q [REG_COUNT];

    logic [5:0]      opcode_s;
    logic [RA_W-1:0] rd_idx_s [2];
    logic [XLEN-1:0] rd_val_s [2];
    logic [RA_W-1:0] rd_s;
    logic [XLEN-1:0] imm_ext_s;
    decode_t         dec_s;
    logic            two_regs_s;
    logic            stall_s;
    logic            bubble_s;

    idex_ctrl_t      ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d, val1_q, val1_d, val2_q, val2_d, st_val_q, st_val_d;
    logic [RA_W-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;

    assign opcode_s    = bus.instr_in[31:26];
    assign rd_idx_s[0] = bus.instr_in[21 +: RA_W];
    assign rd_idx_s[1] = bus.instr_in[16 +: RA_W];
    assign rd_s        = bus.instr_in[11 +: RA_W];
    assign imm_ext_s   = {{(XLEN-16){bus.instr_in[15]}}, bus.instr_in[15:0]};
    assign dec_s       = decode_op(opcode_s);
    assign two_regs_s  = !dec_s.is_imm || (opcode_s == OP_ST) || (opcode_s == OP_BNE);

    // Write-through: a register being written back this cycle is read as its new value.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val_s[p] = {XLEN{1'b0}};
            if (rd_idx_s[p] == {RA_W{1'b0}}) begin
                rd_val_s[p] = {XLEN{1'b0}};
            end else if (bus.wb_en && (bus.wb_dest == rd_idx_s[p])) begin
                rd_val_s[p] = bus.wb_value;
            end else if (int'(rd_idx_s[p]) < REG_COUNT) begin
                rd_val_s[p] = rf_q[rd_idx_s[p]];
            end else begin
                rd_val_s[p] = {XLEN{1'b0}};
            end
        end
    end

    // Register file write port; r0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= {XLEN{1'b0}};
        end else if (bus.wb_en && (bus.wb_dest != {RA_W{1'b0}}) && (int'(bus.wb_dest) < REG_COUNT)) begin
            rf_q[bus.wb_dest] <= bus.wb_value;
        end
    end

    id_hazard_unit #(.RA_W(RA_W), .FORWARD_EN(FORWARD_EN)) u_hazard (
        .instr_valid_i  (bus.instr_valid),
        .flush_i        (bus.flush),
        .two_regs_i     (two_regs_s),
        .src1_i         (rd_idx_s[0]),
        .src2_i         (rd_idx_s[1]),
        .exe_dest_i     (bus.exe_dest),
        .exe_wb_en_i    (bus.exe_wb_en),
        .exe_mem_read_i (bus.exe_mem_read),
        .mem_dest_i     (bus.mem_dest),
        .mem_wb_en_i    (bus.mem_wb_en),
        .stall_o        (stall_s)
    );

    assign bubble_s = bus.flush || stall_s || !bus.instr_valid;

    // Bubbles zero the control word but leave the data fields holding their old values.
    always_comb begin
        ctrl_d   = '0;
        pc_d     = pc_q;
        val1_d   = val1_q;
        val2_d   = val2_q;
        st_val_d = st_val_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        if (bubble_s) begin
            ctrl_d = '0;
        end else begin
            ctrl_d       = dec_s.ctrl;
            ctrl_d.valid = 1'b1;
            pc_d         = bus.pc_in;
            val1_d       = rd_val_s[0];
            val2_d       = dec_s.is_imm ? imm_ext_s : rd_val_s[1];
            st_val_d     = rd_val_s[1];
            dest_d       = dec_s.dest_is_rt ? rd_idx_s[1] : rd_s;
            src1_d       = rd_idx_s[0];
            src2_d       = rd_idx_s[1];
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q   <= '0;
            pc_q     <= {XLEN{1'b0}};
            val1_q   <= {XLEN{1'b0}};
            val2_q   <= {XLEN{1'b0}};
            st_val_q <= {XLEN{1'b0}};
            dest_q   <= {RA_W{1'b0}};
            src1_q   <= {RA_W{1'b0}};
            src2_q   <= {RA_W{1'b0}};
        end else begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            val1_q   <= val1_d;
            val2_q   <= val2_d;
            st_val_q <= st_val_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
        end
    end

    assign bus.stall          = stall_s;
    assign bus.idex_valid     = ctrl_q.valid;
    assign bus.idex_exe_cmd   = ctrl_q.exe_cmd;
    assign bus.idex_mem_read  = ctrl_q.mem_read;
    assign bus.idex_mem_write = ctrl_q.mem_write;
    assign bus.idex_wb_en     = ctrl_q.wb_en;
    assign bus.idex_br_type   = ctrl_q.br_type;
    assign bus.idex_pc        = pc_q;
    assign bus.idex_val1      = val1_q;
    assign bus.idex_val2      = val2_q;
    assign bus.idex_st_val    = st_val_q;
    assign bus.idex_dest      = dest_q;
    assign bus.idex_src1      = src1_q;
    assign bus.idex_src2      = src2_q;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: one instance with forwarding, one without,
// both driven by the same input sequence.
module tb_id_stage_pipelined;
    import core_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic [4:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_read;
    logic [4:0]  mem_dest;
    logic        mem_wb_en;

    int n_pass  = 0;
    int n_total = 0;

    id_stage_pipelined_if #(.XLEN(32), .RA_W(5)) bus_fw ();
    id_stage_pipelined_if #(.XLEN(32), .RA_W(5)) bus_nf ();

    assign bus_fw.instr_in = instr;          assign bus_nf.instr_in = instr;
    assign bus_fw.pc_in = pc;                assign bus_nf.pc_in = pc;
    assign bus_fw.instr_valid = instr_valid; assign bus_nf.instr_valid = instr_valid;
    assign bus_fw.flush = flush;             assign bus_nf.flush = flush;
    assign bus_fw.wb_en = wb_en;             assign bus_nf.wb_en = wb_en;
    assign bus_fw.wb_dest = wb_dest;         assign bus_nf.wb_dest = wb_dest;
    assign bus_fw.wb_value = wb_value;       assign bus_nf.wb_value = wb_value;
    assign bus_fw.exe_dest = exe_dest;       assign bus_nf.exe_dest = exe_dest;
    assign bus_fw.exe_wb_en = exe_wb_en;     assign bus_nf.exe_wb_en = exe_wb_en;
    assign bus_fw.exe_mem_read = exe_mem_read; assign bus_nf.exe_mem_read = exe_mem_read;
    assign bus_fw.mem_dest = mem_dest;       assign bus_nf.mem_dest = mem_dest;
    assign bus_fw.mem_wb_en = mem_wb_en;     assign bus_nf.mem_wb_en = mem_wb_en;

    id_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .FORWARD_EN(1)) dut_fw (
        .clock (clock), .reset (reset), .bus (bus_fw.slave)
    );
    id_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .FORWARD_EN(0)) dut_nf (
        .clock (clock), .reset (reset), .bus (bus_nf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {OP_ADD, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset = 1'b1; instr = 32'h0; pc = 32'h0; instr_valid = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_dest = 5'd0; wb_value = 32'h0;
        exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd0; mem_wb_en = 1'b0;

        // Reset for two cycles
        tick(); tick();
        chk("rst_valid", {31'd0, bus_fw.idex_valid}, 32'd0);
        chk("rst_cmd", {28'd0, bus_fw.idex_exe_cmd}, 32'd0);
        chk("rst_wb", {31'd0, bus_fw.idex_wb_en}, 32'd0);
        chk("rst_val1", bus_fw.idex_val1, 32'd0);
        chk("rst_pc", bus_fw.idex_pc, 32'd0);
        chk("rst_dest", {27'd0, bus_fw.idex_dest}, 32'd0);
        chk("rst_stall_fw", {31'd0, bus_fw.stall}, 32'd0);
        chk("rst_valid_nf", {31'd0, bus_nf.idex_valid}, 32'd0);
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            instr = enc_r(5'(i), 5'(i), 5'd1);
            instr_valid = 1'b1;
            tick();
            chk($sformatf("rf_clear_r%0d", i), bus_fw.idex_val1, 32'd0);
        end

        // Write r5 then read it with ADD rd=3
        instr_valid = 1'b0; wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'h1234;
        tick();
        wb_en = 1'b0;
        chk("idle_bubble", {31'd0, bus_fw.idex_valid}, 32'd0);
        instr = enc_r(5'd5, 5'd5, 5'd3); pc = 32'h100; instr_valid = 1'b1;
        tick();
        chk("add_val1", bus_fw.idex_val1, 32'h1234);
        chk("add_val2", bus_fw.idex_val2, 32'h1234);
        chk("add_dest", {27'd0, bus_fw.idex_dest}, 32'd3);
        chk("add_pc", bus_fw.idex_pc, 32'h100);
        chk("add_cmd", {28'd0, bus_fw.idex_exe_cmd}, 32'd1);
        chk("add_wb", {31'd0, bus_fw.idex_wb_en}, 32'd1);
        chk("add_valid", {31'd0, bus_fw.idex_valid}, 32'd1);

        // Same-cycle write-through with sign-extended immediate
        wb_en = 1'b1; wb_dest = 5'd7; wb_value = 32'hAA;
        instr = enc_i(OP_ADDI, 5'd7, 5'd9, 16'hFFFF);
        tick();
        wb_en = 1'b0;
        chk("addi_val1", bus_fw.idex_val1, 32'hAA);
        chk("addi_val2", bus_fw.idex_val2, 32'hFFFF_FFFF);
        chk("addi_dest", {27'd0, bus_fw.idex_dest}, 32'd9);
        instr = enc_r(5'd7, 5'd5, 5'd2);
        tick();
        chk("r7_kept", bus_fw.idex_val1, 32'hAA);
        chk("r5_kept", bus_fw.idex_val2, 32'h1234);

        // Load-use: LD r4 in EXE, ADD rs=4 in ID
        exe_dest = 5'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        instr = enc_r(5'd4, 5'd0, 5'd2); pc = 32'h200;
        #1;
        chk("lu_stall_fw", {31'd0, bus_fw.stall}, 32'd1);
        chk("lu_stall_nf", {31'd0, bus_nf.stall}, 32'd1);
        tick();
        chk("lu_bubble_fw", {31'd0, bus_fw.idex_valid}, 32'd0);
        chk("lu_bubble_wb", {31'd0, bus_fw.idex_wb_en}, 32'd0);
        chk("lu_bubble_nf", {31'd0, bus_nf.idex_valid}, 32'd0);
        exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd4; mem_wb_en = 1'b1;
        #1;
        chk("mem_stall_fw", {31'd0, bus_fw.stall}, 32'd0);
        chk("mem_stall_nf", {31'd0, bus_nf.stall}, 32'd1);
        tick();
        chk("lu_issue_fw", {31'd0, bus_fw.idex_valid}, 32'd1);
        chk("lu_issue_pc", bus_fw.idex_pc, 32'h200);
        chk("lu_issue_dest", {27'd0, bus_fw.idex_dest}, 32'd2);
        chk("nf_2nd_bubble", {31'd0, bus_nf.idex_valid}, 32'd0);
        mem_dest = 5'd0; mem_wb_en = 1'b0;
        #1;
        chk("nf_stall_clear", {31'd0, bus_nf.stall}, 32'd0);
        tick();
        chk("nf_issue", {31'd0, bus_nf.idex_valid}, 32'd1);
        chk("nf_issue_pc", bus_nf.idex_pc, 32'h200);

        // Non-load RAW against EXE
        exe_dest = 5'd4; exe_wb_en = 1'b1;
        #1;
        chk("raw_exe_fw", {31'd0, bus_fw.stall}, 32'd0);
        chk("raw_exe_nf", {31'd0, bus_nf.stall}, 32'd1);
        exe_dest = 5'd0; exe_wb_en = 1'b0;

        // Store rt against MEM dest
        mem_dest = 5'd6; mem_wb_en = 1'b1;
        instr = enc_i(OP_ST, 5'd1, 5'd6, 16'h0008);
        #1;
        chk("st_rt_nf", {31'd0, bus_nf.stall}, 32'd1);
        chk("st_rt_fw", {31'd0, bus_fw.stall}, 32'd0);
        instr = enc_i(OP_ST, 5'd0, 5'd0, 16'h0008);
        #1;
        chk("st_r0_nf", {31'd0, bus_nf.stall}, 32'd0);
        instr = enc_i(OP_ADDI, 5'd0, 5'd6, 16'h0001);
        #1;
        chk("addi_rt_nf", {31'd0, bus_nf.stall}, 32'd0);
        instr = enc_i(OP_BNE, 5'd0, 5'd6, 16'h0001);
        #1;
        chk("bne_rt_nf", {31'd0, bus_nf.stall}, 32'd1);
        instr = enc_i(OP_ST, 5'd1, 5'd6, 16'h0008); instr_valid = 1'b0;
        #1;
        chk("invalid_nf", {31'd0, bus_nf.stall}, 32'd0);
        mem_dest = 5'd0; mem_wb_en = 1'b0; instr_valid = 1'b1;

        // r0 reads zero even while WB targets r0
        wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hFF;
        instr = enc_r(5'd0, 5'd5, 5'd1);
        tick();
        wb_en = 1'b0;
        chk("r0_val1", bus_fw.idex_val1, 32'd0);
        chk("r0_val2", bus_fw.idex_val2, 32'h1234);

        // Branch decode
        instr = enc_i(OP_BNE, 5'd5, 5'd7, 16'h0010);
        tick();
        chk("bne_br", {30'd0, bus_fw.idex_br_type}, 32'd1);
        chk("bne_st_val", bus_fw.idex_st_val, 32'hAA);
        chk("bne_val2", bus_fw.idex_val2, 32'h10);
        chk("bne_wb", {31'd0, bus_fw.idex_wb_en}, 32'd0);

        // Unknown opcode issues as NOP
        instr = {6'b111111, 26'd0};
        tick();
        chk("unk_valid", {31'd0, bus_fw.idex_valid}, 32'd1);
        chk("unk_cmd", {28'd0, bus_fw.idex_exe_cmd}, 32'd0);
        chk("unk_br", {30'd0, bus_fw.idex_br_type}, 32'd0);

        // Load decode
        instr = enc_i(OP_LD, 5'd5, 5'd8, 16'h0004);
        tick();
        chk("ld_mem_read", {31'd0, bus_fw.idex_mem_read}, 32'd1);
        chk("ld_wb", {31'd0, bus_fw.idex_wb_en}, 32'd1);
        chk("ld_dest", {27'd0, bus_fw.idex_dest}, 32'd8);

        // Flush overrides a live load-use hazard
        exe_dest = 5'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1; flush = 1'b1;
        instr = enc_r(5'd4, 5'd4, 5'd2);
        #1;
        chk("flush_stall_fw", {31'd0, bus_fw.stall}, 32'd0);
        chk("flush_stall_nf", {31'd0, bus_nf.stall}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, bus_fw.idex_valid}, 32'd0);
        chk("flush_mem_read", {31'd0, bus_fw.idex_mem_read}, 32'd0);
        chk("flush_wb", {31'd0, bus_fw.idex_wb_en}, 32'd0);
        chk("flush_cmd", {28'd0, bus_fw.idex_exe_cmd}, 32'd0);
        flush = 1'b0; exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
